// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter: round-robin arbiter that sequences ATM transactions from N_TERM terminals
// against one shared account database (PIN + balance). One transaction is in flight at a time.
// Define ATM_LOCKOUT_EN to add a per-account saturating wrong-PIN lockout counter.
module atm_txn_arbiter #(
    parameter int unsigned N_TERM    = 4,
    parameter int unsigned N_ACC     = 10,
    parameter int unsigned ACC_W     = 4,
    parameter int unsigned PIN_W     = 14,
    parameter int unsigned AMT_W     = 16,
    parameter int unsigned BAL_W     = 32,
    parameter int unsigned MAX_TRIES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TERM-1:0]         req,
    input  logic [N_TERM*3-1:0]       req_op,
    input  logic [N_TERM*ACC_W-1:0]   req_acc,
    input  logic [N_TERM*PIN_W-1:0]   req_pin,
    input  logic [N_TERM*PIN_W-1:0]   req_new_pin,
    input  logic [N_TERM*AMT_W-1:0]   req_amount,
    output logic [N_TERM-1:0]         gnt,
    output logic [N_TERM-1:0]         done,
    output logic                      resp_success,
    output logic [2:0]                resp_code,
    output logic [BAL_W-1:0]          resp_balance,
    output logic [ACC_W-1:0]          db_addr,
    output logic                      db_rd_en,
    input  logic [PIN_W-1:0]          db_rdata_pin,
    input  logic [BAL_W-1:0]          db_rdata_bal,
    output logic                      db_wr_en,
    output logic [PIN_W-1:0]          db_wdata_pin,
    output logic [BAL_W-1:0]          db_wdata_bal
);

    localparam int unsigned TERM_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRead  = 3'd1;
    localparam logic [2:0] StCheck = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    localparam logic [2:0] OpBal = 3'd3;
    localparam logic [2:0] OpWdr = 3'd4;
    localparam logic [2:0] OpDep = 3'd5;
    localparam logic [2:0] OpPin = 3'd6;

    localparam logic [2:0] CodeOk       = 3'd0;
    localparam logic [2:0] CodeBadAcc   = 3'd1;
    localparam logic [2:0] CodeBadPin   = 3'd2;
    localparam logic [2:0] CodeInsuff   = 3'd3;
    localparam logic [2:0] CodeBadOp    = 3'd4;
    localparam logic [2:0] CodeSamePin  = 3'd5;
    localparam logic [2:0] CodeLocked   = 3'd6;
    localparam logic [2:0] CodeOverflow = 3'd7;

    localparam logic [ACC_W-1:0] AccMax = ACC_W'(N_ACC);

    // State and captured transaction
    logic [2:0]        state_q, state_d;
    logic [TERM_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TERM_W-1:0] sel_q, sel_d;
    logic [N_TERM-1:0] gnt_q, gnt_d;
    logic [2:0]        op_q, op_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PIN_W-1:0]  pin_q, pin_d;
    logic [PIN_W-1:0]  new_pin_q, new_pin_d;
    logic [AMT_W-1:0]  amount_q, amount_d;
    logic [PIN_W-1:0]  wpin_q, wpin_d;
    logic [BAL_W-1:0]  wbal_q, wbal_d;
    logic              resp_success_q, resp_success_d;
    logic [2:0]        resp_code_q, resp_code_d;
    logic [BAL_W-1:0]  resp_balance_q, resp_balance_d;

    // Arbitration
    int unsigned       arb_idx;
    logic              arb_found;
    logic [TERM_W-1:0] arb_sel;
    logic [N_TERM-1:0] arb_gnt;
    logic [2:0]        cap_op;
    logic [ACC_W-1:0]  cap_acc;
    logic [PIN_W-1:0]  cap_pin;
    logic [PIN_W-1:0]  cap_new_pin;
    logic [AMT_W-1:0]  cap_amount;
    logic              cap_acc_ok;
    logic              cap_op_ok;

    // Check stage
    logic              pin_bad;
    logic              locked;
    logic [BAL_W-1:0]  amt_ext;
    logic [BAL_W:0]    dep_sum;
    logic [2:0]        chk_code;
    logic [BAL_W-1:0]  chk_bal;
    logic              chk_write;
    logic [PIN_W-1:0]  chk_wpin;
    logic [BAL_W-1:0]  chk_wbal;

    // Round-robin search: first set request at or above rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int unsigned i = 0; i < N_TERM; i++) begin
            arb_idx = ({{(32 - TERM_W){1'b0}}, rr_ptr_q} + i) % N_TERM;
            if (!arb_found && req[TERM_W'(arb_idx)]) begin
                arb_found = 1'b1;
                arb_sel   = TERM_W'(arb_idx);
            end
        end
    end

    // Mux the selected terminal's fields and build the one-hot grant.
    always_comb begin
        cap_op      = '0;
        cap_acc     = '0;
        cap_pin     = '0;
        cap_new_pin = '0;
        cap_amount  = '0;
        arb_gnt     = '0;
        for (int unsigned k = 0; k < N_TERM; k++) begin
            if (arb_sel == TERM_W'(k)) begin
                cap_op      = req_op[k*3 +: 3];
                cap_acc     = req_acc[k*ACC_W +: ACC_W];
                cap_pin     = req_pin[k*PIN_W +: PIN_W];
                cap_new_pin = req_new_pin[k*PIN_W +: PIN_W];
                cap_amount  = req_amount[k*AMT_W +: AMT_W];
                arb_gnt[k]  = arb_found;
            end
        end
    end

    assign cap_acc_ok = (cap_acc != '0) && (cap_acc <= AccMax);
    assign cap_op_ok  = (cap_op >= OpBal) && (cap_op <= OpPin);

    assign pin_bad = (db_rdata_pin != pin_q);
    assign amt_ext = {{(BAL_W - AMT_W){1'b0}}, amount_q};
    assign dep_sum = {1'b0, db_rdata_bal} + {1'b0, amt_ext};

`ifdef ATM_LOCKOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_TRIES);

    logic [CNT_W-1:0] lock_cnt_q [N_ACC];
    logic [CNT_W-1:0] lock_cnt_d [N_ACC];
    logic [ACC_W-1:0] acc_idx;

    assign acc_idx = acc_q - ACC_W'(1);
    assign locked  = (lock_cnt_q[acc_idx] == CntMax);

    // Wrong PIN bumps the count; a correct PIN below the limit clears it. Locked accounts freeze.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if ((state_q == StCheck) && !locked) begin
            if (pin_bad) begin
                lock_cnt_d[acc_idx] = lock_cnt_q[acc_idx] + CNT_W'(1);
            end else begin
                lock_cnt_d[acc_idx] = '0;
            end
        end
    end

    // Lockout counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_ACC; i++) begin
                lock_cnt_q[i] <= '0;
            end
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign locked = 1'b0;
`endif

    // Evaluate the op against the record read from the database.
    always_comb begin
        chk_code  = CodeOk;
        chk_bal   = '0;
        chk_write = 1'b0;
        chk_wpin  = db_rdata_pin;
        chk_wbal  = db_rdata_bal;
        if (locked) begin
            chk_code = CodeLocked;
        end else if (pin_bad) begin
            chk_code = CodeBadPin;
        end else begin
            case (op_q)
                OpBal: chk_bal = db_rdata_bal;
                OpWdr: begin
                    if (amt_ext > db_rdata_bal) begin
                        chk_code = CodeInsuff;
                    end else begin
                        chk_write = 1'b1;
                        chk_wbal  = db_rdata_bal - amt_ext;
                    end
                end
                OpDep: begin
                    if (dep_sum[BAL_W]) begin
                        chk_code = CodeOverflow;
                    end else begin
                        chk_write = 1'b1;
                        chk_wbal  = dep_sum[BAL_W-1:0];
                    end
                end
                OpPin: begin
                    if (new_pin_q == db_rdata_pin) begin
                        chk_code = CodeSamePin;
                    end else begin
                        chk_write = 1'b1;
                        chk_wpin  = new_pin_q;
                    end
                end
                default: chk_code = CodeBadOp;
            endcase
        end
    end

    // Transaction FSM next-state and captured-data updates.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        sel_d          = sel_q;
        gnt_d          = gnt_q;
        op_d           = op_q;
        acc_d          = acc_q;
        pin_d          = pin_q;
        new_pin_d      = new_pin_q;
        amount_d       = amount_q;
        wpin_d         = wpin_q;
        wbal_d         = wbal_q;
        resp_success_d = resp_success_q;
        resp_code_d    = resp_code_q;
        resp_balance_d = resp_balance_q;
        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    sel_d     = arb_sel;
                    gnt_d     = arb_gnt;
                    op_d      = cap_op;
                    acc_d     = cap_acc;
                    pin_d     = cap_pin;
                    new_pin_d = cap_new_pin;
                    amount_d  = cap_amount;
                    if (!cap_acc_ok) begin
                        state_d        = StResp;
                        resp_code_d    = CodeBadAcc;
                        resp_success_d = 1'b0;
                        resp_balance_d = '0;
                    end else if (!cap_op_ok) begin
                        state_d        = StResp;
                        resp_code_d    = CodeBadOp;
                        resp_success_d = 1'b0;
                        resp_balance_d = '0;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: state_d = StCheck;
            StCheck: begin
                if (chk_write) begin
                    state_d = StWrite;
                    wpin_d  = chk_wpin;
                    wbal_d  = chk_wbal;
                end else begin
                    state_d        = StResp;
                    resp_code_d    = chk_code;
                    resp_success_d = (chk_code == CodeOk);
                    resp_balance_d = chk_bal;
                end
            end
            StWrite: begin
                // Written balance is also the reported one (unchanged balance for a PIN change).
                state_d        = StResp;
                resp_code_d    = CodeOk;
                resp_success_d = 1'b1;
                resp_balance_d = wbal_q;
            end
            StResp: begin
                state_d  = StIdle;
                gnt_d    = '0;
                rr_ptr_d = (sel_q == TERM_W'(N_TERM - 1)) ? '0 : sel_q + TERM_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            sel_q          <= '0;
            gnt_q          <= '0;
            op_q           <= '0;
            acc_q          <= '0;
            pin_q          <= '0;
            new_pin_q      <= '0;
            amount_q       <= '0;
            wpin_q         <= '0;
            wbal_q         <= '0;
            resp_success_q <= 1'b0;
            resp_code_q    <= '0;
            resp_balance_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            sel_q          <= sel_d;
            gnt_q          <= gnt_d;
            op_q           <= op_d;
            acc_q          <= acc_d;
            pin_q          <= pin_d;
            new_pin_q      <= new_pin_d;
            amount_q       <= amount_d;
            wpin_q         <= wpin_d;
            wbal_q         <= wbal_d;
            resp_success_q <= resp_success_d;
            resp_code_q    <= resp_code_d;
            resp_balance_q <= resp_balance_d;
        end
    end

    assign gnt          = gnt_q;
    assign done         = (state_q == StResp) ? gnt_q : '0;
    assign resp_success = resp_success_q;
    assign resp_code    = resp_code_q;
    assign resp_balance = resp_balance_q;
    assign db_rd_en     = (state_q == StRead);
    assign db_wr_en     = (state_q == StWrite);
    // Address only driven while the database is being accessed.
    assign db_addr      = (db_rd_en || db_wr_en) ? acc_q - ACC_W'(1) : '0;
    assign db_wdata_pin = wpin_q;
    assign db_wdata_bal = wbal_q;

endmodule
